ftdi_fifo_responder: RTL and testbench
======================================

Name: ftdi_fifo_responder

Overview:
- Synthesizable device-side model of the FTDI asynchronous 245-FIFO interface; the chip end of the host interface.
- Answers the host's ftdi_rd/ftdi_wr strobes and drives rxf/txe and the data bus.
- Buffers bytes in an RX FIFO (PC→FPGA) and a TX FIFO (FPGA→PC).
- Used for on-board loopback and bring-up of the laser link without a USB host attached.

Parameters:
DEPTH, 16, entries per FIFO; power of 2, minimum 2.
RXF_GAP, 1, minimum cycles rxf stays high after each pop.
TXE_GAP, 1, minimum cycles txe stays high after each push.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous reset, active-low
clear  in  1  synchronous: empty both FIFOs, clear error flags, FSM to IDLE
ftdi_rd  in  1  host read strobe, active-low
ftdi_wr  in  1  host write strobe, active-low
adbus_tri  in  1  host is driving the bus
adbus_in  in  8  bus value driven by host
rxf  out  1  active-low: byte available to host
txe  out  1  active-low: space for a host write
adbus_oe  out  1  responder drives the bus
adbus_out  out  8  bus value driven by responder
pc_wr_valid  in  1  PC-side byte offered to RX FIFO
pc_wr_data  in  8  PC-side byte
pc_wr_ready  out  1  RX FIFO not full
pc_rd_valid  out  1  TX FIFO not empty
pc_rd_data  out  8  TX FIFO head
pc_rd_ready  in  1  PC side consumes head
rx_count  out  $clog2(DEPTH)+1  RX occupancy
tx_count  out  $clog2(DEPTH)+1  TX occupancy
err_underrun, err_overflow, err_conflict  out  1 each  sticky protocol errors

Behaviour:
- Reset (reset_n low, async): FSM IDLE; FIFOs empty; rxf=1; txe=1; adbus_oe=0; adbus_out=0; counts 0; errors 0; gap counter 0.
- rxf and txe are registered outputs.
  - rxf=0 iff FSM in IDLE, RX not empty, and no RXF_GAP pending.
  - txe=0 iff FSM in IDLE, TX not full, and no TXE_GAP pending.
- adbus_oe = !ftdi_rd && !adbus_tri, combinational. Data must be valid in the same cycle the host drops ftdi_rd.
- adbus_out = RX head while RX is non-empty, else 0.
- FSM states: IDLE, RD_ACTIVE, WR_ACTIVE, GAP.
  - IDLE, ftdi_rd=0, ftdi_wr=1:
    - If RX is non-empty: pop at this edge, go to RD_ACTIVE, rxf goes high next cycle.
    - If RX is empty: set err_underrun, no pop, go to RD_ACTIVE.
  - IDLE, ftdi_wr=0, ftdi_rd=1, adbus_tri=1:
    - If TX is not full: push adbus_in at this edge, go to WR_ACTIVE.
    - If TX is full: set err_overflow, drop the byte, go to WR_ACTIVE.
  - IDLE, ftdi_wr=0 with adbus_tri=0: no push; wait in IDLE for adbus_tri.
  - IDLE, ftdi_rd=0 and ftdi_wr=0 together: set err_conflict, no push, no pop, go to GAP.
  - RD_ACTIVE: hold until ftdi_rd=1, then go to GAP loaded with RXF_GAP-1. Exactly one pop per strobe regardless of its length.
  - WR_ACTIVE: hold until ftdi_wr=1, then go to GAP loaded with TXE_GAP-1. Exactly one push per strobe.
  - GAP: count down; go to IDLE at 0. A gap of 0 means straight to IDLE.
- Strobe while not in IDLE: no additional transfer. A 2-cycle write strobe pushes once.
- adbus_tri=1 while adbus_oe would be 1: set err_conflict.
- PC side uses a valid/ready handshake.
  - RX push when pc_wr_valid && pc_wr_ready.
  - TX pop when pc_rd_valid && pc_rd_ready.
  - Same-cycle host pop and PC push on a full RX FIFO: both allowed; count unchanged. Same rule for TX.
- Pointers wrap modulo DEPTH; counts saturate at DEPTH by construction.
- clear has priority over all transfers in that cycle.
- Reset mid-strobe: the FSM returns to IDLE. A strobe still held low after reset is treated as a new request.

Optional Feature:
FTDI_RESP_LOOPBACK_EN:
- When defined:
  - The TX FIFO head is moved into the RX FIFO whenever TX is non-empty and RX is not full, one byte per cycle.
  - PC ports are inert: pc_wr_ready=0, pc_rd_valid=0, pc_rd_data=0.
- When undefined: the PC ports behave as specified above.

Decomposition:
- Package ftdi_pkg holds:
  - state enum ftdi_resp_state_t {IDLE, RD_ACTIVE, WR_ACTIVE, GAP};
  - constant BYTE_W=8.
- Sub-module byte_fifo (DEPTH parameter, push/pop/clear, head, count, full, empty), instantiated twice for RX and TX.

Test Plan:
- Preload RX with 0xA5, 0x3C via PC port; host read strobe one cycle low, twice. Required: adbus_out=0xA5 during the first low cycle and 0x3C during the second; rxf high in the cycle after each strobe; rx_count 2→1→0; after the second read, rxf stays high.
- Host writes 0x5A with a 2-cycle wr strobe and adbus_tri=1. Required: exactly one push; pc_rd_valid=1, pc_rd_data=0x5A; txe high for ≥TXE_GAP cycles after release.
- Fill TX to 16 with pc_rd_ready=0. Required: txe stays 1. Then force a host write with ftdi_wr=0. Required: err_overflow=1, tx_count stays 16.
- Assert ftdi_rd and ftdi_wr low in the same cycle. Required: err_conflict=1, no count change. Pulse clear. Required: flags return to 0.
- Assert reset_n low during RD_ACTIVE. Required: rxf=txe=1, adbus_oe follows ftdi_rd only, counts 0; normal operation resumes after release.
- With FTDI_RESP_LOOPBACK_EN defined, host writes 0x11, 0x22, 0x33, then reads three bytes. Required: the reads return 0x11, 0x22, 0x33 in order.

Source files
------------

// File: rtl/ftdi_pkg.sv
// ftdi_pkg: shared types and constants for the FTDI 245-FIFO responder.
//   ftdi_resp_state_t : responder FSM states
//   BYTE_W            : width of the FTDI data bus and FIFO entries
package ftdi_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_ACTIVE,
    WR_ACTIVE,
    GAP
  } ftdi_resp_state_t;

endpackage

// File: rtl/ftdi_fifo_responder_if.sv
// ftdi_fifo_responder_if: host-side FTDI async 245-FIFO bus.
//   ftdi_rd, ftdi_wr : host strobes, active-low
//   adbus_tri        : host is driving the bus
//   adbus_in         : value the host drives
//   rxf, txe         : chip status, active-low
//   adbus_oe         : chip drives the bus
//   adbus_out        : value the chip drives
// Modports: master = USB host side, slave = chip (responder) side.
interface ftdi_fifo_responder_if;
  import ftdi_pkg::*;

  logic              ftdi_rd;
  logic              ftdi_wr;
  logic              adbus_tri;
  logic [BYTE_W-1:0] adbus_in;
  logic              rxf;
  logic              txe;
  logic              adbus_oe;
  logic [BYTE_W-1:0] adbus_out;

  modport master (
    output ftdi_rd, ftdi_wr, adbus_tri, adbus_in,
    input  rxf, txe, adbus_oe, adbus_out
  );

  modport slave (
    input  ftdi_rd, ftdi_wr, adbus_tri, adbus_in,
    output rxf, txe, adbus_oe, adbus_out
  );

endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO, DEPTH entries (power of 2, >= 2).
//   clock, reset_n : clock, async active-low reset
//   clear          : synchronous empty
//   push, din      : write one byte (caller guarantees room, or a same-cycle pop)
//   pop            : drop the head (caller guarantees non-empty)
//   head           : byte at the read pointer
//   count          : occupancy 0..DEPTH
//   full, empty    : occupancy flags
module byte_fifo
  import ftdi_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ftdi_fifo_responder.sv
// ftdi_fifo_responder: device-side model of the FTDI async 245-FIFO chip.
// Answers host ftdi_rd/ftdi_wr strobes, drives rxf/txe and the data bus,
// buffering PC->FPGA bytes in an RX FIFO and FPGA->PC bytes in a TX FIFO.
//   clock, reset_n       : clock, async active-low reset
//   clear                : sync: empty FIFOs, clear errors, FSM to IDLE
//   bus (slave)          : host strobes, bus and rxf/txe status
//   pc_wr_valid/data/ready : PC side feeding the RX FIFO
//   pc_rd_valid/data/ready : PC side draining the TX FIFO
//   rx_count, tx_count   : FIFO occupancies
//   err_underrun/overflow/conflict : sticky protocol errors
// Build option: FTDI_RESP_LOOPBACK_EN moves TX bytes into RX internally and
// makes the PC ports inert.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned RXF_GAP = 1,
  parameter int unsigned TXE_GAP = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  ftdi_fifo_responder_if.slave   bus,
  input  logic                   pc_wr_valid,
  input  logic [BYTE_W-1:0]      pc_wr_data,
  output logic                   pc_wr_ready,
  output logic                   pc_rd_valid,
  output logic [BYTE_W-1:0]      pc_rd_data,
  input  logic                   pc_rd_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   err_underrun,
  output logic                   err_overflow,
  output logic                   err_conflict
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned GAP_MAX = (RXF_GAP > TXE_GAP) ? RXF_GAP : TXE_GAP;
  localparam int unsigned GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX);

  ftdi_resp_state_t  state, state_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;

  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [BYTE_W-1:0] rx_din, tx_din, rx_head, tx_head;

  logic              host_pop, host_push;
  logic              set_underrun, set_overflow, set_conflict;
  logic              rxf_q, txe_q;
  logic [CW-1:0]     rx_cnt_nxt, tx_cnt_nxt;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (rx_push),
    .pop     (rx_pop),
    .din     (rx_din),
    .head    (rx_head),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (tx_push),
    .pop     (tx_pop),
    .din     (tx_din),
    .head    (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // Read data is presented combinationally so it is valid in the same
  // cycle the host drops ftdi_rd.
  assign bus.adbus_oe  = !bus.ftdi_rd && !bus.adbus_tri;
  assign bus.adbus_out = rx_empty ? '0 : rx_head;
  assign bus.rxf       = rxf_q;
  assign bus.txe       = txe_q;

  assign rx_pop  = host_pop;
  assign tx_push = host_push;
  assign tx_din  = bus.adbus_in;

`ifdef FTDI_RESP_LOOPBACK_EN
  logic lb_move;
  logic unused_pc;

  assign lb_move     = !tx_empty && !rx_full && !clear;
  assign rx_push     = lb_move;
  assign rx_din      = tx_head;
  assign tx_pop      = lb_move;
  assign pc_wr_ready = 1'b0;
  assign pc_rd_valid = 1'b0;
  assign pc_rd_data  = '0;
  assign unused_pc   = ^{pc_wr_valid, pc_wr_data, pc_rd_ready};
`else
  // A host pop in the same cycle frees a slot, so a full RX can still
  // accept a PC byte.
  assign pc_wr_ready = (!rx_full || host_pop) && !clear;
  assign rx_push     = pc_wr_valid && pc_wr_ready;
  assign rx_din      = pc_wr_data;
  assign pc_rd_valid = !tx_empty;
  assign pc_rd_data  = tx_empty ? '0 : tx_head;
  assign tx_pop      = pc_rd_valid && pc_rd_ready && !clear;
`endif

  always_comb begin
    state_n      = state;
    gap_n        = gap_cnt;
    host_pop     = 1'b0;
    host_push    = 1'b0;
    set_underrun = 1'b0;
    set_overflow = 1'b0;
    set_conflict = !bus.ftdi_rd && bus.adbus_tri;

    unique case (state)
      IDLE: begin
        if (!bus.ftdi_rd && !bus.ftdi_wr) begin
          set_conflict = 1'b1;
          state_n      = GAP;
          gap_n        = '0;
        end else if (!bus.ftdi_rd) begin
          if (rx_empty) set_underrun = 1'b1;
          else          host_pop     = 1'b1;
          state_n = RD_ACTIVE;
        end else if (!bus.ftdi_wr && bus.adbus_tri) begin
          // A PC pop in the same cycle makes room on a full TX.
          if (tx_full && !tx_pop) set_overflow = 1'b1;
          else                    host_push    = 1'b1;
          state_n = WR_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (bus.ftdi_rd) begin
          if (RXF_GAP == 0) begin
            state_n = IDLE;
          end else begin
            state_n = GAP;
            gap_n   = GAP_W'(RXF_GAP - 1);
          end
        end
      end
      WR_ACTIVE: begin
        if (bus.ftdi_wr) begin
          if (TXE_GAP == 0) begin
            state_n = IDLE;
          end else begin
            state_n = GAP;
            gap_n   = GAP_W'(TXE_GAP - 1);
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_n   = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (clear) begin
      state_n      = IDLE;
      gap_n        = '0;
      host_pop     = 1'b0;
      host_push    = 1'b0;
      set_underrun = 1'b0;
      set_overflow = 1'b0;
      set_conflict = 1'b0;
    end
  end

  // rxf/txe are registered from the post-edge state and occupancy so that
  // status drops in the very cycle after a transfer.
  always_comb begin
    rx_cnt_nxt = clear ? '0 : rx_count + CW'(rx_push) - CW'(rx_pop);
    tx_cnt_nxt = clear ? '0 : tx_count + CW'(tx_push) - CW'(tx_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      rxf_q   <= 1'b1;
      txe_q   <= 1'b1;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      rxf_q   <= !(state_n == IDLE && rx_cnt_nxt != '0);
      txe_q   <= !(state_n == IDLE && tx_cnt_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
      err_conflict <= 1'b0;
    end else if (clear) begin
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      err_underrun <= err_underrun | set_underrun;
      err_overflow <= err_overflow | set_overflow;
      err_conflict <= err_conflict | set_conflict;
    end
  end

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// tb_ftdi_fifo_responder: directed-vector bench for ftdi_fifo_responder
// (DEPTH=16, RXF_GAP=1, TXE_GAP=1). Expected values are hand-derived.
module tb_ftdi_fifo_responder;
  import ftdi_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              clear;
  logic              pc_wr_valid;
  logic [BYTE_W-1:0] pc_wr_data;
  logic              pc_wr_ready;
  logic              pc_rd_valid;
  logic [BYTE_W-1:0] pc_rd_data;
  logic              pc_rd_ready;
  logic [4:0]        rx_count;
  logic [4:0]        tx_count;
  logic              err_underrun, err_overflow, err_conflict;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ftdi_fifo_responder_if bus ();

  ftdi_fifo_responder #(
    .DEPTH   (16),
    .RXF_GAP (1),
    .TXE_GAP (1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear        (clear),
    .bus          (bus.slave),
    .pc_wr_valid  (pc_wr_valid),
    .pc_wr_data   (pc_wr_data),
    .pc_wr_ready  (pc_wr_ready),
    .pc_rd_valid  (pc_rd_valid),
    .pc_rd_data   (pc_rd_data),
    .pc_rd_ready  (pc_rd_ready),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .err_underrun (err_underrun),
    .err_overflow (err_overflow),
    .err_conflict (err_conflict)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and checks
  // are made 1 ns later, well away from either edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle host write strobe followed by the release and gap cycles.
  task automatic host_write(input logic [BYTE_W-1:0] b);
    bus.ftdi_wr = 1'b0; bus.adbus_tri = 1'b1; bus.adbus_in = b;
    tick();
    bus.ftdi_wr = 1'b1; bus.adbus_tri = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0;
    bus.ftdi_rd = 1'b1; bus.ftdi_wr = 1'b1; bus.adbus_tri = 1'b0; bus.adbus_in = '0;
    pc_wr_valid = 1'b0; pc_wr_data = '0; pc_rd_ready = 1'b0;
    repeat (2) tick();

    check("rst_rxf", bus.rxf, 1'b1);
    check("rst_txe", bus.txe, 1'b1);
    check("rst_oe", bus.adbus_oe, 1'b0);
    check("rst_out", bus.adbus_out, 8'h00);
    check("rst_rxcnt", rx_count, 5'd0);
    check("rst_txcnt", tx_count, 5'd0);
    check("rst_errs", {err_underrun, err_overflow, err_conflict}, 3'b000);

    reset_n = 1'b1;
    tick();
    check("idle_txe", bus.txe, 1'b0);
    check("idle_rxf", bus.rxf, 1'b1);

`ifdef FTDI_RESP_LOOPBACK_EN
    check("lb_wr_ready", pc_wr_ready, 1'b0);
    host_write(8'h11);
    host_write(8'h22);
    host_write(8'h33);
    tick();
    check("lb_rxcnt", rx_count, 5'd3);
    check("lb_txcnt", tx_count, 5'd0);
    check("lb_rxf", bus.rxf, 1'b0);
    begin
      logic [BYTE_W-1:0] exp_b [3];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
        bus.ftdi_rd = 1'b0;
        #1;
        check("lb_rd_data", bus.adbus_out, exp_b[i]);
        tick();
        bus.ftdi_rd = 1'b1;
        tick();
        tick();
      end
    end
    check("lb_rx_empty", rx_count, 5'd0);
`else
    // Preload RX from the PC side.
    pc_wr_valid = 1'b1; pc_wr_data = 8'hA5;
    tick();
    pc_wr_data = 8'h3C;
    tick();
    pc_wr_valid = 1'b0;
    #1;
    check("pre_rxcnt", rx_count, 5'd2);
    check("pre_rxf", bus.rxf, 1'b0);

    // First one-cycle read strobe.
    bus.ftdi_rd = 1'b0;
    #1;
    check("rd1_oe", bus.adbus_oe, 1'b1);
    check("rd1_data", bus.adbus_out, 8'hA5);
    tick();
    bus.ftdi_rd = 1'b1;
    #1;
    check("rd1_rxf_hi", bus.rxf, 1'b1);
    check("rd1_rxcnt", rx_count, 5'd1);
    tick();
    check("rd1_gap_rxf", bus.rxf, 1'b1);
    tick();
    check("rd1_idle_rxf", bus.rxf, 1'b0);

    // Second read strobe.
    bus.ftdi_rd = 1'b0;
    #1;
    check("rd2_data", bus.adbus_out, 8'h3C);
    tick();
    bus.ftdi_rd = 1'b1;
    #1;
    check("rd2_rxf_hi", bus.rxf, 1'b1);
    check("rd2_rxcnt", rx_count, 5'd0);
    tick();
    tick();
    check("rd2_rxf_stay", bus.rxf, 1'b1);
    check("rd2_out_zero", bus.adbus_out, 8'h00);

    // Two-cycle write strobe: exactly one push.
    bus.ftdi_wr = 1'b0; bus.adbus_tri = 1'b1; bus.adbus_in = 8'h5A;
    tick();
    check("wr_txcnt1", tx_count, 5'd1);
    check("wr_txe_hi", bus.txe, 1'b1);
    tick();
    bus.ftdi_wr = 1'b1; bus.adbus_tri = 1'b0;
    #1;
    check("wr_one_push", tx_count, 5'd1);
    check("wr_rd_valid", pc_rd_valid, 1'b1);
    check("wr_rd_data", pc_rd_data, 8'h5A);
    tick();
    check("wr_gap_txe", bus.txe, 1'b1);
    tick();
    check("wr_idle_txe", bus.txe, 1'b0);
    check("wr_no_conf", err_conflict, 1'b0);

    // Fill TX to 16 with the PC side stalled.
    for (int i = 1; i <= 15; i++) host_write(8'(i));
    tick();
    check("full_txcnt", tx_count, 5'd16);
    check("full_txe", bus.txe, 1'b1);

    // Host write into a full TX.
    bus.ftdi_wr = 1'b0; bus.adbus_tri = 1'b1; bus.adbus_in = 8'hFF;
    tick();
    bus.ftdi_wr = 1'b1; bus.adbus_tri = 1'b0;
    #1;
    check("ovf_flag", err_overflow, 1'b1);
    check("ovf_txcnt", tx_count, 5'd16);
    tick();
    tick();

    // Drain one byte from the PC side.
    check("drain_head", pc_rd_data, 8'h5A);
    pc_rd_ready = 1'b1;
    tick();
    pc_rd_ready = 1'b0;
    #1;
    check("drain_txcnt", tx_count, 5'd15);
    check("drain_next", pc_rd_data, 8'h01);

    // Simultaneous strobes.
    bus.ftdi_rd = 1'b0; bus.ftdi_wr = 1'b0;
    tick();
    bus.ftdi_rd = 1'b1; bus.ftdi_wr = 1'b1;
    #1;
    check("conf_flag", err_conflict, 1'b1);
    check("conf_rxcnt", rx_count, 5'd0);
    check("conf_txcnt", tx_count, 5'd15);
    tick();
    tick();

    // Read from empty RX.
    bus.ftdi_rd = 1'b0;
    tick();
    bus.ftdi_rd = 1'b1;
    #1;
    check("und_flag", err_underrun, 1'b1);
    tick();
    tick();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    check("clr_errs", {err_underrun, err_overflow, err_conflict}, 3'b000);
    check("clr_txcnt", tx_count, 5'd0);
    check("clr_txe", bus.txe, 1'b0);

    // Reset during RD_ACTIVE.
    pc_wr_valid = 1'b1; pc_wr_data = 8'h77;
    tick();
    pc_wr_valid = 1'b0;
    tick();
    bus.ftdi_rd = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_rxf", bus.rxf, 1'b1);
    check("mid_rst_txe", bus.txe, 1'b1);
    check("mid_rst_oe1", bus.adbus_oe, 1'b1);
    check("mid_rst_rxcnt", rx_count, 5'd0);
    bus.ftdi_rd = 1'b1;
    #1;
    check("mid_rst_oe0", bus.adbus_oe, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_txe", bus.txe, 1'b0);

    // Normal operation after reset.
    pc_wr_valid = 1'b1; pc_wr_data = 8'h42;
    tick();
    pc_wr_valid = 1'b0;
    #1;
    check("post_rst_rxf", bus.rxf, 1'b0);
    bus.ftdi_rd = 1'b0;
    #1;
    check("post_rst_data", bus.adbus_out, 8'h42);
    tick();
    bus.ftdi_rd = 1'b1;
    #1;
    check("post_rst_rxcnt", rx_count, 5'd0);
    check("post_rst_und", err_underrun, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
